// File: rtl/fb_sched_pkg.sv
// Shared types, coefficients and the RGB565 -> grayscale helper for the
// frame buffer read scheduler.
package fb_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fb_sched_state_t;

  typedef enum logic {SRC_CAPTURE = 1'b0, SRC_PC = 1'b1} fb_src_t;

  localparam int unsigned Y_COEF_R = 77;
  localparam int unsigned Y_COEF_G = 150;
  localparam int unsigned Y_COEF_B = 29;

  // 8 data bits + {sof, eol, eof}
  localparam int unsigned FIFO_WIDTH = 11;

  // Channels are widened by bit replication; the weighted sum peaks at 65280,
  // so 16 bits never overflow.
  function automatic logic [7:0] rgb565_to_y(input logic [15:0] px);
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;
    r8  = {px[15:11], px[15:13]};
    g8  = {px[10:5], px[10:9]};
    b8  = {px[4:0], px[4:2]};
    sum = 16'(Y_COEF_R) * 16'(r8) + 16'(Y_COEF_G) * 16'(g8) + 16'(Y_COEF_B) * 16'(b8);
    return sum[15:8];
  endfunction

endpackage

// File: rtl/fb_read_scheduler_if.sv
// Frame buffer read ports and the grayscale output stream of the scheduler.
interface fb_read_scheduler_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  cap_fb_re;
  logic [ADDR_WIDTH-1:0] cap_fb_rAddr;
  logic [15:0]           cap_fb_rData;
  logic                  pc_fb_re;
  logic [ADDR_WIDTH-1:0] pc_fb_rAddr;
  logic [15:0]           pc_fb_rData;
  logic                  m_valid;
  logic                  m_ready;
  logic [7:0]            m_data;
  logic                  m_sof;
  logic                  m_eol;
  logic                  m_eof;

  modport master (
    output cap_fb_re, cap_fb_rAddr, pc_fb_re, pc_fb_rAddr,
    input  cap_fb_rData, pc_fb_rData,
    output m_valid, m_data, m_sof, m_eol, m_eof,
    input  m_ready
  );

  modport slave (
    input  cap_fb_re, cap_fb_rAddr, pc_fb_re, pc_fb_rAddr,
    output cap_fb_rData, pc_fb_rData,
    input  m_valid, m_data, m_sof, m_eol, m_eof,
    output m_ready
  );
endinterface

// File: rtl/fb_skid_fifo.sv
// Two-entry FIFO that absorbs returning frame buffer data while the stream
// consumer stalls.
module fb_skid_fifo #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_pop;

  assign do_pop = pop && (count_q != 2'd0);
  assign rdata  = mem_q[rd_ptr_q];
  assign count  = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, do_pop};
    end
  end

  // The upstream credit check keeps pushes away from a full FIFO.
  assert property (@(posedge clk) disable iff (!reset) !(push && !flush && count_q == 2'd2))
    else $error("fb_skid_fifo: push into full FIFO");

endmodule

// File: rtl/fb_read_scheduler.sv
// Reads one stored RGB565 frame in raster order from the selected frame
// buffer and streams it as 8-bit grayscale with sof/eol/eof framing.
module fb_read_scheduler
  import fb_sched_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 176,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                src_sel,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  fb_read_scheduler_if.master bus
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [XW-1:0]         X_LAST    = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]         Y_LAST    = YW'(IMG_HEIGHT - 1);

  fb_sched_state_t       state_q;
  fb_src_t               src_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic                  inflight_q;
  logic [2:0]            flags_q;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  drain_done;
  logic [2:0]            credit;
  logic [1:0]            fifo_count;
  logic [15:0]           rdata_sel;
  logic [FIFO_WIDTH-1:0] fifo_wdata;
  logic [FIFO_WIDTH-1:0] fifo_head;

  assign pop    = bus.m_valid && bus.m_ready;
  // Entries held or on their way, after this cycle's pop, must leave room for one more.
  assign credit = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue  = (state_q == RUN) && !abort && (credit < 3'd2);

  assign bus.cap_fb_re    = issue && (src_q == SRC_CAPTURE);
  assign bus.pc_fb_re     = issue && (src_q == SRC_PC);
  assign bus.cap_fb_rAddr = (src_q == SRC_CAPTURE) ? addr_q : '0;
  assign bus.pc_fb_rAddr  = (src_q == SRC_PC) ? addr_q : '0;

  assign rdata_sel  = (src_q == SRC_PC) ? bus.pc_fb_rData : bus.cap_fb_rData;
  assign push       = inflight_q && !abort;
  assign fifo_wdata = {flags_q, rgb565_to_y(rdata_sel)};

  // Lets done follow the eof handshake by exactly one cycle.
  assign drain_done = !inflight_q &&
                      ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

  fb_skid_fifo #(
    .WIDTH(FIFO_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .flush(abort),
    .push (push),
    .wdata(fifo_wdata),
    .pop  (pop),
    .rdata(fifo_head),
    .count(fifo_count)
  );

  assign bus.m_valid = (fifo_count != 2'd0);
  assign bus.m_data  = fifo_head[7:0];
  assign bus.m_sof   = fifo_head[10];
  assign bus.m_eol   = fifo_head[9];
  assign bus.m_eof   = fifo_head[8];

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      src_q      <= SRC_CAPTURE;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= 1'b0;
      flags_q    <= '0;
    end else if (abort) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= 1'b0;
      flags_q    <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        flags_q <= {(x_q == '0) && (y_q == '0),
                    (x_q == X_LAST),
                    (x_q == X_LAST) && (y_q == Y_LAST)};
        addr_q  <= addr_q + 1'b1;
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
      unique case (state_q)
        IDLE: begin
          addr_q <= '0;
          x_q    <= '0;
          y_q    <= '0;
          if (start) begin
            src_q   <= fb_src_t'(src_sel);
            state_q <= RUN;
          end
        end
        RUN: begin
          if (issue && (addr_q == ADDR_LAST)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_read_scheduler.sv
// Directed bench for fb_read_scheduler: reset, full capture frame, grayscale
// corner pixels, stalled PC-source stream and abort/restart.
module tb_fb_read_scheduler;

  localparam int W  = 176;
  localparam int H  = 240;
  localparam int N  = W * H;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic src_sel;
  logic abort;
  logic busy;
  logic done;

  int checks = 0;
  int errors = 0;
  int cap_mode = 0;

  fb_read_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

  fb_read_scheduler #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .src_sel(src_sel),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] cap_word(input logic [AW-1:0] a);
    if (cap_mode == 1) begin
      case (a)
        16'd0:   return 16'hFFFF;
        16'd1:   return 16'hF800;
        16'd2:   return 16'h07E0;
        16'd3:   return 16'h001F;
        16'd4:   return 16'h0000;
        default: return 16'h1234;
      endcase
    end else if (cap_mode == 2) begin
      return ~a;
    end
    return a;
  endfunction

  function automatic logic [15:0] pc_word(input logic [AW-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd40503 + 32'd7;
    return t[15:0] ^ 16'hA5C3;
  endfunction

  // Frame buffers answer one cycle after the read enable.
  always @(posedge clk) begin
    if (bus.cap_fb_re) bus.cap_fb_rData <= cap_word(bus.cap_fb_rAddr);
    if (bus.pc_fb_re) bus.pc_fb_rData <= pc_word(bus.pc_fb_rAddr);
  end

  function automatic int gold_y(input logic [15:0] px);
    int r, g, b;
    r = int'(px[15:11]);
    g = int'(px[10:5]);
    b = int'(px[4:0]);
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  function automatic logic [47:0] outs_vec();
    return {busy, done, bus.cap_fb_re, bus.cap_fb_rAddr, bus.pc_fb_re, bus.pc_fb_rAddr,
            bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof};
  endfunction

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; src_sel = 1'b0; abort = 1'b0;
    bus.m_ready = 1'b1; cap_mode = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs_vec() !== 48'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", outs_vec());
    end
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus.m_valid !== 1'b1) begin
      errors++; $display("FAIL mid_run: got busy=%b valid=%b expected 1 1", busy, bus.m_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (outs_vec() !== 48'h0) begin
      errors++; $display("FAIL async_reset: got %h expected 0", outs_vec());
    end
    @(negedge clk);
    checks++;
    if (outs_vec() !== 48'h0) begin
      errors++; $display("FAIL reset_next_cycle: got %h expected 0", outs_vec());
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.m_valid !== 1'b0 || bus.cap_fb_re !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b re=%b expected 0 0 0",
               busy, bus.m_valid, bus.cap_fb_re);
    end
  endtask

  task automatic test_full_frame();
    int cyc = 0, beats = 0, bad_data = 0, bad_flags = 0, eols = 0, dones = 0;
    int done_cyc = -1, eof_cyc = -1, eof_beat = -1, first_valid = -1, pc_seen = 0;
    bit fin = 1'b0;
    cap_mode = 0; src_sel = 1'b0; bus.m_ready = 1'b1;
    start = 1'b1;
    while (!fin && cyc < 43000) begin
      @(negedge clk);
      cyc++;
      start   = (cyc == 100 || cyc == 20000) ? 1'b1 : 1'b0;
      src_sel = (cyc >= 100) ? 1'b1 : 1'b0;
      #1;
      if (bus.pc_fb_re) pc_seen++;
      if (bus.m_valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          start = 1'b1;  // lands in DONE, must be ignored
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        if (int'(bus.m_data) !== gold_y(16'(beats))) bad_data++;
        if (bus.m_sof !== (beats == 0) || bus.m_eol !== (beats % W == W - 1) ||
            bus.m_eof !== (beats == N - 1)) bad_flags++;
        if (bus.m_eol) eols++;
        if (bus.m_eof) begin
          eof_cyc = cyc; eof_beat = beats;
        end
        beats++;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 6) fin = 1'b1;
    end
    start = 1'b0; src_sel = 1'b0;
    checks++;
    if (!fin) begin errors++; $display("FAIL frame_timeout: got no done expected done"); end
    checks++;
    if (beats !== N) begin errors++; $display("FAIL beat_count: got %0d expected %0d", beats, N); end
    checks++;
    if (first_valid !== 3) begin
      errors++; $display("FAIL first_valid_latency: got %0d expected 3", first_valid);
    end
    checks++;
    if (bad_data !== 0) begin errors++; $display("FAIL frame_data: got %0d bad expected 0", bad_data); end
    checks++;
    if (bad_flags !== 0) begin
      errors++; $display("FAIL frame_flags: got %0d bad expected 0", bad_flags);
    end
    checks++;
    if (eols !== H) begin errors++; $display("FAIL eol_count: got %0d expected %0d", eols, H); end
    checks++;
    if (eof_beat !== N - 1) begin
      errors++; $display("FAIL eof_beat: got %0d expected %0d", eof_beat, N - 1);
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL done_count: got %0d expected 1", dones); end
    checks++;
    if (done_cyc !== eof_cyc + 1) begin
      errors++; $display("FAIL done_timing: got %0d expected %0d", done_cyc, eof_cyc + 1);
    end
    checks++;
    if (pc_seen !== 0) begin errors++; $display("FAIL pc_re_seen: got %0d expected 0", pc_seen); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done: got busy=%b expected 0", busy); end
  endtask

  task automatic test_gray();
    int exp_y[5] = '{255, 76, 149, 28, 0};
    int cyc = 0, beats = 0;
    cap_mode = 1; src_sel = 1'b0; bus.m_ready = 1'b1;
    start = 1'b1;
    while (beats < 5 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      #1;
      if (bus.m_valid && bus.m_ready) begin
        checks++;
        if (int'(bus.m_data) !== exp_y[beats]) begin
          errors++;
          $display("FAIL gray_px%0d: got %0d expected %0d", beats, bus.m_data, exp_y[beats]);
        end
        beats++;
      end
    end
    checks++;
    if (beats !== 5) begin errors++; $display("FAIL gray_beats: got %0d expected 5", beats); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL gray_abort: got busy=%b valid=%b expected 0 0", busy, bus.m_valid);
    end
  endtask

  task automatic test_pc_random();
    int cyc = 0, beats = 0, bad = 0, bad_flags = 0, stall_bad = 0, stalls = 0, cap_seen = 0;
    bit pend = 1'b0;
    logic [10:0] hold;
    cap_mode = 0; src_sel = 1'b1; bus.m_ready = 1'b1;
    start = 1'b1;
    while (beats < 2000 && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      src_sel = cyc[0];
      bus.m_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.cap_fb_re) cap_seen++;
      if (pend && (!bus.m_valid ||
                   {bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof} !== hold)) stall_bad++;
      pend = bus.m_valid && !bus.m_ready;
      if (pend) begin
        hold = {bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof};
        stalls++;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (int'(bus.m_data) !== gold_y(pc_word(16'(beats)))) bad++;
        if (bus.m_sof !== (beats == 0) || bus.m_eol !== (beats % W == W - 1) ||
            bus.m_eof !== 1'b0) bad_flags++;
        beats++;
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; bus.m_ready = 1'b1; src_sel = 1'b0;
    checks++;
    if (beats !== 2000) begin errors++; $display("FAIL pc_beats: got %0d expected 2000", beats); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL pc_data: got %0d bad expected 0", bad); end
    checks++;
    if (bad_flags !== 0) begin errors++; $display("FAIL pc_flags: got %0d bad expected 0", bad_flags); end
    checks++;
    if (stall_bad !== 0) begin
      errors++; $display("FAIL stall_stable: got %0d bad expected 0", stall_bad);
    end
    checks++;
    if (stalls == 0) begin errors++; $display("FAIL stall_seen: got 0 expected >0"); end
    checks++;
    if (cap_seen !== 0) begin errors++; $display("FAIL cap_re_seen: got %0d expected 0", cap_seen); end
  endtask

  task automatic test_abort();
    int cyc = 0, beats = 0, dones = 0, busy_seen = 0, first_addr = -1;
    bit got = 1'b0;
    cap_mode = 2; src_sel = 1'b0; bus.m_ready = 1'b1;
    start = 1'b1;
    while (beats < 1000 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      #1;
      if (bus.m_valid && bus.m_ready) beats++;
    end
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.m_valid !== 1'b0 || bus.cap_fb_re !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b valid=%b re=%b expected 0 0 0",
               busy, bus.m_valid, bus.cap_fb_re);
    end
    repeat (6) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busy_seen++;
    end
    checks++;
    if (dones !== 0 || busy_seen !== 0) begin
      errors++; $display("FAIL abort_quiet: got done=%0d busy=%0d expected 0 0", dones, busy_seen);
    end
    start = 1'b1;
    cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      #1;
      if (bus.cap_fb_re && first_addr < 0) first_addr = int'(bus.cap_fb_rAddr);
      if (bus.m_valid && bus.m_ready) begin
        got = 1'b1;
        checks++;
        if (bus.m_data !== 8'd255 || bus.m_sof !== 1'b1 || bus.m_eol !== 1'b0) begin
          errors++;
          $display("FAIL restart_beat: got data=%0d sof=%b eol=%b expected 255 1 0",
                   bus.m_data, bus.m_sof, bus.m_eol);
        end
      end
    end
    checks++;
    if (first_addr !== 0 || !got) begin
      errors++; $display("FAIL restart_addr: got %0d expected 0", first_addr);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_gray();
    test_pc_random();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
